// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin output-registered mux.
package rr_mux_pkg;

  localparam int unsigned ChMin = 2;
  localparam int unsigned ChMax = 16;

  // Index width for n channels; n >= 2 always yields at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr_i, wrapping to 0.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned CH = 4,
  localparam int unsigned IdxW = idx_width(CH)
) (
  input  logic [CH-1:0]   req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic            en_i,
  output logic [CH-1:0]   gnt_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < CH; off++) begin
      cand = 32'(ptr_i) + off;
      if (cand >= CH) begin
        cand = cand - CH;
      end
      if (en_i && !found && req_i[IdxW'(cand)]) begin
        found                = 1'b1;
        gnt_o[IdxW'(cand)]   = 1'b1;
        idx_o                = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// Round-robin N:1 mux with a single registered output stage and full throughput.
// Optional packet locking (in_last port) is enabled by defining RR_MUX_LOCK_EN.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CH    = 4,
  localparam int unsigned IdxW = idx_width(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
`ifdef RR_MUX_LOCK_EN
  input  logic [CH-1:0]       in_last,
`endif
  output logic [CH-1:0]       in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IdxW-1:0]     out_ch
);

  if (CH < ChMin || CH > ChMax) begin : g_ch_range
    $error("rr_mux: CH out of supported range");
  end

  logic             free;
  logic             accept;
  logic [CH-1:0]    req;
  logic [CH-1:0]    gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic [IdxW-1:0]  ptr_inc;
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;

  // Output slot can take a new beat if empty or being drained this cycle.
  assign free = !valid_q || out_ready;

`ifdef RR_MUX_LOCK_EN
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    req = in_valid;
    if (lock_q) begin
      req            = '0;
      req[lock_ch_q] = in_valid[lock_ch_q];
    end
  end
`else
  assign req = in_valid;
`endif

  rr_arbiter #(
    .CH(CH)
  ) u_arbiter (
    .req_i(req),
    .ptr_i(ptr_q),
    .en_i (free),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );

  assign in_ready = gnt;
  assign accept   = |gnt;
  assign ptr_inc  = (gnt_idx == IdxW'(CH - 1)) ? '0 : gnt_idx + IdxW'(1);

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (gnt[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef RR_MUX_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
`endif
    if (accept) begin
      data_d  = sel_data;
      ch_d    = gnt_idx;
      valid_d = 1'b1;
      ptr_d   = ptr_inc;
`ifdef RR_MUX_LOCK_EN
      // Mid-packet beats hold the pointer so rotation resumes after the packet.
      if (in_last[gnt_idx]) begin
        lock_d = 1'b0;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = gnt_idx;
        ptr_d     = ptr_q;
      end
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux (CH=4, WIDTH=16): directed cases plus randomized traffic.
module tb_rr_mux;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CH    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_last;
  logic [CH-1:0]       in_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_ch;

  always #5 clk = ~clk;

  rr_mux #(
    .WIDTH(WIDTH),
    .CH   (CH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef RR_MUX_LOCK_EN
    .in_last  (in_last),
`endif
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               ch;
  } beat_t;

  beat_t sbq[$];
  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;

  // Reference model state: occupancy of the output slot, rotation pointer, packet lock.
  bit mdl_valid;
  int mdl_ptr;
  bit mdl_lock;
  int mdl_lock_ch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  // One clock cycle: model evaluates the inputs already applied, then the edge is taken.
  task automatic step();
    int          k;
    bit          free_m;
    logic [CH-1:0] exp_rdy;
    beat_t       b;
    @(negedge clk);
    check("out_valid", out_valid, mdl_valid);
    free_m = !mdl_valid || out_ready;
    k = -1;
    if (free_m) begin
      for (int off = 0; off < CH; off++) begin
        int c;
        c = (mdl_ptr + off) % CH;
        if (k < 0 && in_valid[c] && (!mdl_lock || c == mdl_lock_ch)) k = c;
      end
    end
    exp_rdy = '0;
    if (k >= 0) exp_rdy[k] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    if (k >= 0) begin
      b.data = in_data[k*WIDTH +: WIDTH];
      b.ch   = k;
      sbq.push_back(b);
      mdl_valid = 1'b1;
      if (in_last[k]) begin
        mdl_lock = 1'b0;
        mdl_ptr  = (k + 1) % CH;
      end else begin
        mdl_lock    = 1'b1;
        mdl_lock_ch = k;
      end
    end else if (out_ready) begin
      mdl_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_outs);
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    #1;
    if (check_outs) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 16'h0000);
      check("rst_out_ch", out_ch, 0);
    end
    sbq.delete();
    mdl_valid   = 1'b0;
    mdl_ptr     = 0;
    mdl_lock    = 1'b0;
    mdl_lock_ch = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: whenever a beat is presented it must match the oldest expected beat.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && rst_n && out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=ch%0d/%0h required=no beat", out_ch, out_data);
        end else begin
          check("beat_data", out_data, sbq[0].data);
          check("beat_ch", out_ch, sbq[0].ch);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '1;
    out_ready = 1'b0;
    #2;
    do_reset(1'b1);
    mon_en = 1'b1;

    // Rotation with all channels requesting.
    for (int i = 0; i < CH; i++) set_data(i, 16'hA000 + 16'(i));
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rot_ch", out_ch, i % CH);
      check("rot_valid", out_valid, 1);
    end

    // Backpressure holding a ch2 beat.
    in_valid = 4'b0100;
    set_data(2, 16'h1234);
    step();
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < CH; c++) set_data(c, 16'($urandom));
      step();
      check("bp_data", out_data, 16'h1234);
      check("bp_ch", out_ch, 2);
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 4'b0000);
    end

    // Sparse requests from pointer 1.
    out_ready = 1'b1;
    step();
    do_reset(1'b0);
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    step();
    in_valid = 4'b1000;
    step();
    check("sparse_ch3", out_ch, 3);
    in_valid = 4'b1001;
    step();
    check("sparse_ch0", out_ch, 0);

    // Simultaneous pop and push.
    in_valid = 4'b0010;
    set_data(1, 16'h5A5A);
    step();
    check("popush_ch", out_ch, 1);
    check("popush_valid", out_valid, 1);
    check("popush_data", out_data, 16'h5A5A);

    // Asynchronous reset with a beat held; first grant afterwards starts at ch0.
    check("pre_rst_valid", out_valid, 1);
    do_reset(1'b1);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    check("post_rst_ch", out_ch, 0);

`ifdef RR_MUX_LOCK_EN
    do_reset(1'b0);
    in_last   = '1;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    step();
    in_valid = 4'b0111;
    for (int b = 0; b < 4; b++) begin
      in_last    = '1;
      in_last[1] = (b == 2);
      step();
      check("lock_ch", out_ch, (b < 3) ? 1 : 2);
    end
    in_last = '1;
`endif

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < CH; c++) set_data(c, 16'($urandom));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_MUX_LOCK_EN
      for (int c = 0; c < CH; c++) in_last[c] = ($urandom_range(0, 2) != 0);
`endif
      step();
    end

    in_valid  = '0;
    in_last   = '1;
    out_ready = 1'b1;
    repeat (3) step();
    check("drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
